// File: rtl/data_req_win_if.sv
// Read-request bus between the window request generator and the data BRAM side.
// The generator drives the request outputs; the controller/BRAM side drives start, abort and stall.
interface data_req_win_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_start;
    logic                  i_abort;
    logic                  i_stall;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic                  o_rden;
    logic                  o_line_end;
    logic                  o_win_end;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        input  i_start, i_abort, i_stall,
        output o_addr, o_rden, o_line_end, o_win_end, o_busy, o_done, o_err
    );

    modport slave (
        output i_start, i_abort, i_stall,
        input  o_addr, o_rden, o_line_end, o_win_end, o_busy, o_done, o_err
    );
endinterface

// File: rtl/data_req_win.sv
// Walks every KxK window of a WxH feature map (vertical stride S) and issues K lines of W word
// reads per window to the data BRAM, stalling cleanly on back-pressure.
module data_req_win #(
    parameter int ADDR_WIDTH  = 32,
    parameter int REG_WIDTH   = 32,
    parameter int DIM_WIDTH   = 8,
    parameter int KSIZE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    data_req_win_if.master        bus,
    input  logic [ADDR_WIDTH-1:0] i_conf_baseaddr,
    input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
    input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
    input  logic [REG_WIDTH-1:0]  i_conf_stride,
    output logic [REG_WIDTH-1:0]  dbg_knline_cnt,
    output logic [REG_WIDTH-1:0]  dbg_addr_reg
);

    // Compare width wide enough that rbase+S+K can never wrap.
    localparam int CW = ((DIM_WIDTH > KSIZE_WIDTH) ? DIM_WIDTH : KSIZE_WIDTH) + 2;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  base_r;
    logic [DIM_WIDTH-1:0]   w_r;
    logic [DIM_WIDTH-1:0]   h_r;
    logic [KSIZE_WIDTH-1:0] k_r;
    logic [KSIZE_WIDTH-1:0] s_r;
    logic                   err_r;
    logic [ADDR_WIDTH-1:0]  stride_words;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [ADDR_WIDTH-1:0]  line_addr;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DIM_WIDTH-1:0]   wcnt;
    logic [KSIZE_WIDTH-1:0] kcnt;
    logic [DIM_WIDTH-1:0]   rbase;

    logic                   rd_fire;
    logic                   w_last;
    logic                   k_last;
    logic                   last_win;
    logic                   bad_cfg;
    logic [ADDR_WIDTH-1:0]  w_ext;
    logic [ADDR_WIDTH-1:0]  next_win;
    logic                   unused_cfg;

    assign unused_cfg = ^{i_conf_inputshape[REG_WIDTH-1:2*DIM_WIDTH],
                          i_conf_kernelshape[REG_WIDTH-1:KSIZE_WIDTH],
                          i_conf_stride[REG_WIDTH-1:KSIZE_WIDTH]};

    assign rd_fire  = (state == RUN) && !rst && !bus.i_stall && !bus.i_abort;
    assign w_last   = (wcnt == w_r - DIM_WIDTH'(1));
    assign k_last   = (kcnt == k_r - KSIZE_WIDTH'(1));
    assign last_win = (CW'(rbase) + CW'(s_r) + CW'(k_r)) > CW'(h_r);
    assign bad_cfg  = (w_r == '0) || (k_r == '0) || (s_r == '0) || (CW'(k_r) > CW'(h_r));
    assign w_ext    = ADDR_WIDTH'(w_r);
    assign next_win = win_addr + stride_words;

    // Single FSM: latch config on start, prime address registers in LOAD, then step one read
    // per unstalled RUN cycle; abort drops straight back to IDLE without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base_r       <= '0;
            w_r          <= '0;
            h_r          <= '0;
            k_r          <= '0;
            s_r          <= '0;
            err_r        <= 1'b0;
            stride_words <= '0;
            win_addr     <= '0;
            line_addr    <= '0;
            addr         <= '0;
            wcnt         <= '0;
            kcnt         <= '0;
            rbase        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        base_r <= i_conf_baseaddr;
                        w_r    <= i_conf_inputshape[DIM_WIDTH-1:0];
                        h_r    <= i_conf_inputshape[2*DIM_WIDTH-1:DIM_WIDTH];
                        k_r    <= i_conf_kernelshape[KSIZE_WIDTH-1:0];
                        s_r    <= i_conf_stride[KSIZE_WIDTH-1:0];
                        err_r  <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.i_abort) begin
                        state <= IDLE;
                    end else begin
                        stride_words <= ADDR_WIDTH'(s_r) * ADDR_WIDTH'(w_r);
                        win_addr     <= base_r;
                        line_addr    <= base_r;
                        addr         <= base_r;
                        wcnt         <= '0;
                        kcnt         <= '0;
                        rbase        <= '0;
                        if (bad_cfg) begin
                            err_r <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_abort) begin
                        state <= IDLE;
                    end else if (rd_fire) begin
                        if (!w_last) begin
                            addr <= addr + ADDR_WIDTH'(1);
                            wcnt <= wcnt + DIM_WIDTH'(1);
                        end else if (!k_last) begin
                            line_addr <= line_addr + w_ext;
                            addr      <= line_addr + w_ext;
                            wcnt      <= '0;
                            kcnt      <= kcnt + KSIZE_WIDTH'(1);
                        end else begin
                            wcnt      <= '0;
                            kcnt      <= '0;
                            rbase     <= rbase + DIM_WIDTH'(s_r);
                            win_addr  <= next_win;
                            line_addr <= next_win;
                            addr      <= next_win;
                            if (last_win) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by rst so everything reads zero while reset is held.
    assign bus.o_rden     = rd_fire;
    assign bus.o_addr     = rst ? '0 : addr;
    assign bus.o_line_end = rd_fire && w_last;
    assign bus.o_win_end  = rd_fire && w_last && k_last;
    assign bus.o_busy     = !rst && ((state == LOAD) || (state == RUN));
    assign bus.o_done     = !rst && (state == DONE);
    assign bus.o_err      = !rst && (state == DONE) && err_r;
    assign dbg_knline_cnt = rst ? '0 : REG_WIDTH'(kcnt);
    assign dbg_addr_reg   = rst ? '0 : REG_WIDTH'(addr);

endmodule

// File: tb/tb_data_req_win.sv
// Self-checking bench for data_req_win: fixed config table, targeted stall/abort/reset sequences
// and random jobs, all compared against a window-walk reference model.
module tb_data_req_win;

    localparam int AW = 32;
    localparam int RW = 32;
    localparam int DW = 8;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_base;
    logic [RW-1:0] cfg_shape;
    logic [RW-1:0] cfg_kernel;
    logic [RW-1:0] cfg_stride;
    logic [RW-1:0] dbg_kn;
    logic [RW-1:0] dbg_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_req_win_if #(.ADDR_WIDTH(AW)) bus ();

    data_req_win #(
        .ADDR_WIDTH(AW), .REG_WIDTH(RW), .DIM_WIDTH(DW), .KSIZE_WIDTH(KW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .i_conf_baseaddr    (cfg_base),
        .i_conf_inputshape  (cfg_shape),
        .i_conf_kernelshape (cfg_kernel),
        .i_conf_stride      (cfg_stride),
        .dbg_knline_cnt     (dbg_kn),
        .dbg_addr_reg       (dbg_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        le;
        logic        we;
        int          kl;
    } rd_t;

    rd_t exp_q[$];

    typedef struct {
        logic [31:0] base;
        int          w, h, k, s;
        int          exp_reads;
        logic        exp_err;
        logic [31:0] exp_last;
    } vec_t;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: enumerate window top rows r = 0, S, 2S, ... while r+K <= H, each window
    // reading K lines of W consecutive words.
    task automatic build_expected(input logic [31:0] base, input int w, h, k, s, output logic err);
        rd_t e;
        exp_q.delete();
        err = (w == 0) || (k == 0) || (s == 0) || (k > h);
        if (!err) begin
            for (int r = 0; r + k <= h; r += s)
                for (int kk = 0; kk < k; kk++)
                    for (int ww = 0; ww < w; ww++) begin
                        e.addr = base + 32'((r + kk) * w + ww);
                        e.le   = (ww == w - 1);
                        e.we   = (ww == w - 1) && (kk == k - 1);
                        e.kl   = kk;
                        exp_q.push_back(e);
                    end
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] base, input int w, h, k, s,
                                  input int stall_pct, input int stall_read, input int stall_len,
                                  input int abort_read,
                                  output int nreads, output logic err_seen, output logic [31:0] last_addr);
        logic exp_err;
        logic done_seen;
        logic stall_armed;
        int   cyc, first_cyc, last_rd_cyc, stall_left, viol;
        rd_t  e;
        build_expected(base, w, h, k, s, exp_err);
        nreads = 0; err_seen = 1'b0; last_addr = '0;
        done_seen = 1'b0; stall_armed = (stall_read != 0);
        first_cyc = -1; last_rd_cyc = 0; stall_left = 0;

        @(negedge clk);
        cfg_base   = base;
        cfg_shape  = RW'((h << DW) | w);
        cfg_kernel = RW'(k);
        cfg_stride = RW'(s);
        bus.i_start = 1'b1; bus.i_stall = 1'b0; bus.i_abort = 1'b0;
        #1 check_output("idle_busy", bus.o_busy, 0);
        @(negedge clk);
        bus.i_start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 4000) begin
            if (cyc == 2) begin
                cfg_base = $urandom; cfg_shape = $urandom; cfg_kernel = $urandom; cfg_stride = $urandom;
            end
            if (stall_armed && cyc >= 2 && nreads + 1 == stall_read) begin
                stall_left = stall_len; stall_armed = 1'b0;
            end
            if (stall_left > 0) begin
                bus.i_stall = 1'b1; stall_left--;
            end else begin
                bus.i_stall = ($urandom_range(99) < stall_pct);
            end
            if (abort_read != 0 && cyc >= 2 && nreads + 1 == abort_read && !bus.i_stall) begin
                bus.i_abort = 1'b1;
                #1 check_output("abort_rden", bus.o_rden, 0);
                @(negedge clk);
                bus.i_abort = 1'b0;
                #1 check_output("abort_busy", bus.o_busy, 0);
                viol = 0;
                repeat (6) begin
                    if (bus.o_done || bus.o_rden) viol++;
                    @(negedge clk);
                    #1;
                end
                check_output("abort_no_done", viol, 0);
                return;
            end
            #1;
            if (bus.i_stall) check_output("stall_rden", bus.o_rden, 0);
            if (bus.o_rden) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_output("extra_read", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("rd_addr", bus.o_addr, e.addr);
                    check_output("rd_line_end", bus.o_line_end, e.le);
                    check_output("rd_win_end", bus.o_win_end, e.we);
                    check_output("dbg_addr", dbg_addr, e.addr);
                    check_output("dbg_knline", dbg_kn, e.kl);
                end
                nreads++; last_addr = bus.o_addr; last_rd_cyc = cyc;
            end else if (bus.i_stall && bus.o_busy && cyc >= 2 && exp_q.size() > 0) begin
                check_output("stall_addr_hold", bus.o_addr, exp_q[0].addr);
            end
            if (bus.o_done) begin
                done_seen = 1'b1; err_seen = bus.o_err;
                if (first_cyc < 0) first_cyc = cyc;
                if (nreads > 0) check_output("done_timing", cyc, last_rd_cyc + 1);
            end
            @(negedge clk);
            cyc++;
        end
        bus.i_stall = 1'b0;
        check_output("done_seen", done_seen, 1);
        check_output("missing_reads", exp_q.size(), 0);
        check_output("err_model", err_seen, exp_err);
        if (stall_pct == 0 && stall_read == 0) check_output("first_latency", first_cyc, 2);
        #1 check_output("done_pulse", {bus.o_done, bus.o_busy}, 2'b00);
    endtask

    task automatic reset_sequence();
        int n, guard, viol;
        @(negedge clk);
        cfg_base = 32'h100; cfg_shape = RW'((4 << DW) | 4); cfg_kernel = 3; cfg_stride = 1;
        bus.i_start = 1'b1; bus.i_stall = 1'b0; bus.i_abort = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b0;
        n = 0; guard = 0;
        while (n < 3 && guard < 50) begin
            #1;
            if (bus.o_rden) n++;
            if (n < 3) @(negedge clk);
            guard++;
        end
        check_output("reset_seq_reads", n, 3);
        @(negedge clk);
        bus.i_start = 1'b1;
        #1 check_output("midrun_start_addr", {bus.o_rden, bus.o_addr}, {1'b1, 32'h103});
        @(negedge clk);
        bus.i_start = 1'b0;
        #1 check_output("midrun_no_restart", {bus.o_rden, bus.o_addr}, {1'b1, 32'h104});
        @(negedge clk);
        rst = 1'b1;
        #1 check_output("rst_ctrl", {bus.o_rden, bus.o_line_end, bus.o_win_end, bus.o_busy, bus.o_done, bus.o_err}, 0);
        check_output("rst_addr", {bus.o_addr, dbg_addr}, 0);
        check_output("rst_dbg_kn", dbg_kn, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check_output("post_rst_state", {bus.o_busy, bus.o_addr, dbg_kn}, 0);
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            #1 if (bus.o_rden || bus.o_busy || bus.o_done) viol++;
        end
        check_output("post_rst_idle", viol, 0);
    endtask

    initial begin
        vec_t        tbl[10];
        int          nreads;
        logic        err_seen;
        logic [31:0] last_addr;

        tbl[0] = '{32'h100,      4, 4, 3, 1, 24, 1'b0, 32'h10F};
        tbl[1] = '{32'h0,        2, 5, 2, 2,  8, 1'b0, 32'h7};
        tbl[2] = '{32'h40,       3, 4, 0, 1,  0, 1'b1, 32'h0};
        tbl[3] = '{32'h40,       3, 5, 2, 0,  0, 1'b1, 32'h0};
        tbl[4] = '{32'h0,        3, 5, 6, 1,  0, 1'b1, 32'h0};
        tbl[5] = '{32'h0,        0, 5, 2, 1,  0, 1'b1, 32'h0};
        tbl[6] = '{32'h200,      1, 1, 1, 1,  1, 1'b0, 32'h200};
        tbl[7] = '{32'h10,       3, 3, 3, 2,  9, 1'b0, 32'h18};
        tbl[8] = '{32'hFFFFFFFE, 2, 2, 1, 1,  4, 1'b0, 32'h1};
        tbl[9] = '{32'h0,        2, 6, 2, 3,  8, 1'b0, 32'h9};

        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_stall = 1'b0;
        cfg_base = '0; cfg_shape = '0; cfg_kernel = '0; cfg_stride = '0;
        repeat (2) @(negedge clk);
        #1 check_output("reset_state", {bus.o_rden, bus.o_busy, bus.o_done, bus.o_err, bus.o_addr, dbg_addr}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(tbl[i].base, tbl[i].w, tbl[i].h, tbl[i].k, tbl[i].s, 0, 0, 0, 0,
                           nreads, err_seen, last_addr);
            check_output($sformatf("tbl%0d_reads", i), nreads, tbl[i].exp_reads);
            check_output($sformatf("tbl%0d_err", i), err_seen, tbl[i].exp_err);
            if (tbl[i].exp_reads > 0) check_output($sformatf("tbl%0d_last", i), last_addr, tbl[i].exp_last);
        end

        // Three-cycle stall on the 5th read: address must hold 0x104 and the stream resume intact.
        apply_stimulus(32'h100, 4, 4, 3, 1, 0, 5, 3, 0, nreads, err_seen, last_addr);
        check_output("stall_reads", nreads, 24);

        // Abort at read 7, then a fresh start must replay from the base address.
        apply_stimulus(32'h100, 4, 4, 3, 1, 0, 0, 0, 7, nreads, err_seen, last_addr);
        check_output("abort_reads", nreads, 6);
        apply_stimulus(32'h100, 4, 4, 3, 1, 0, 0, 0, 0, nreads, err_seen, last_addr);
        check_output("replay_reads", nreads, 24);

        reset_sequence();

        for (int i = 0; i < 20; i++) begin
            apply_stimulus($urandom, $urandom_range(1, 6), $urandom_range(1, 8), $urandom_range(0, 4),
                           $urandom_range(0, 3), 30, 0, 0, 0, nreads, err_seen, last_addr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
